// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write initiator and its slave receiver:
// state encodings, the slave address and the quarter-bit phase numbers.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_DATA     = 4'd4,
    ST_DATA_ACK = 4'd5,
    ST_STOP     = 4'd6
  } state_e;

  localparam logic [6:0] SLAVE_ADDR = 7'b0101010;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  // 1 means the open-drain driver pulls the line low.
  typedef struct packed {
    logic scl_low;
    logic sda_low;
  } line_drive_t;

  // Line levels for a given state/phase; bit_val is the bit currently on the wire.
  function automatic line_drive_t line_levels(state_e st, logic [1:0] ph, logic bit_val);
    line_drive_t d;
    d.scl_low = 1'b0;
    d.sda_low = 1'b0;
    case (st)
      ST_START: begin
        d.scl_low = 1'b0;
        d.sda_low = (ph == P2) || (ph == P3);
      end
      ST_ADDR, ST_DATA: begin
        d.scl_low = (ph == P0) || (ph == P1);
        d.sda_low = !bit_val;
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        d.scl_low = (ph == P0) || (ph == P1);
        d.sda_low = 1'b0;
      end
      ST_STOP: begin
        d.scl_low = (ph == P0) || (ph == P1);
        d.sda_low = (ph != P3);
      end
      default: begin
        d.scl_low = 1'b0;
        d.sda_low = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one-cycle pulse every CLK_DIV cycles while en is high,
// counter parked at zero otherwise so every frame starts on a fresh tick boundary.
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_master_writer.sv
// Single-byte I2C write initiator: START, address+W, ACK check, one data byte,
// ACK check, STOP. SCL/SDA are open-drain (drive 0 or release), no clock stretching.
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic [3:0] state_out,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);

  state_e      state_q;
  logic [1:0]  phase_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  sreg_q;
  logic [7:0]  data_q;
  logic        ack_bit_q;
  logic        busy_q;
  logic        done_q;
  logic        ack_error_q;
  line_drive_t drive_q;
  logic        sda_meta_q;
  logic        sda_sync_q;
  logic        tick;

  i2c_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= i2c_sda;
      sda_sync_q <= sda_meta_q;
    end
  end

  // The line drivers follow state/phase one cycle later, so the wire never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= P0;
      bit_cnt_q   <= 3'd7;
      sreg_q      <= '0;
      data_q      <= '0;
      ack_bit_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      drive_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      drive_q <= line_levels(state_q, phase_q, sreg_q[7]);
      if (state_q == ST_IDLE) begin
        if (start) begin
          state_q     <= ST_START;
          phase_q     <= P0;
          sreg_q      <= {addr, 1'b0};
          data_q      <= data_in;
          ack_error_q <= 1'b0;
          busy_q      <= 1'b1;
        end
      end else if (tick) begin
        phase_q <= phase_q + 2'd1;
        if ((phase_q == P2) && ((state_q == ST_ADDR_ACK) || (state_q == ST_DATA_ACK))) begin
          ack_bit_q <= sda_sync_q;
        end
        if (phase_q == P3) begin
          case (state_q)
            ST_START: begin
              state_q   <= ST_ADDR;
              bit_cnt_q <= 3'd7;
            end
            ST_ADDR: begin
              if (bit_cnt_q == 3'd0) begin
                state_q <= ST_ADDR_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
                sreg_q    <= {sreg_q[6:0], 1'b0};
              end
            end
            ST_ADDR_ACK: begin
              if (ack_bit_q) begin
                ack_error_q <= 1'b1;
                state_q     <= ST_STOP;
              end else begin
                state_q   <= ST_DATA;
                sreg_q    <= data_q;
                bit_cnt_q <= 3'd7;
              end
            end
            ST_DATA: begin
              if (bit_cnt_q == 3'd0) begin
                state_q <= ST_DATA_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
                sreg_q    <= {sreg_q[6:0], 1'b0};
              end
            end
            ST_DATA_ACK: begin
              if (ack_bit_q) begin
                ack_error_q <= 1'b1;
              end
              state_q <= ST_STOP;
            end
            ST_STOP: begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            default: begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign i2c_scl   = drive_q.scl_low ? 1'b0 : 1'bz;
  assign i2c_sda   = drive_q.sda_low ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
  assign state_out = state_q;

endmodule
